// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: collects WIDTH bits in either order and hands the word out
// through a single-entry valid/ready output register. Define PARITY_CHK_EN to add an even-parity bit per frame.
module shift_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             msb_first,
    input  logic             din,
    input  logic             din_vld,
    input  logic             q_rdy,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Q,
    output logic             q_vld,
    output logic             busy,
    output logic             ovr,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_CHK_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             msb_q, msb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_vld_q, q_vld_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr_shift;
    logic             load;
    logic [WIDTH-1:0] load_word;

    assign sr_shift = msb_q ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};

    // Frame collection; start has priority over any data bit in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;
        sr_d      = sr_q;
        load      = 1'b0;
        load_word = sr_q;
        if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            msb_d   = msb_first;
            sr_d    = '0;
        end else if (din_vld) begin
            case (state_q)
                SHIFT: begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
`ifdef PARITY_CHK_EN
                        state_d = PAR;
`else
                        state_d   = IDLE;
                        cnt_d     = '0;
                        load      = 1'b1;
                        load_word = sr_shift;
`endif
                    end
                end
`ifdef PARITY_CHK_EN
                PAR: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    load      = 1'b1;
                    load_word = sr_q;
                end
`endif
                default: ;
            endcase
        end
    end

    // Output slot: a completed word only lands if the slot is free or being drained this cycle.
    always_comb begin
        q_d     = q_q;
        q_vld_d = q_vld_q;
        ovr_d   = err_clr ? 1'b0 : ovr_q;
        if (load) begin
            if (!q_vld_q || q_rdy) begin
                q_d     = load_word;
                q_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (q_vld_q && q_rdy) begin
            q_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            sr_q    <= '0;
            q_q     <= '0;
            q_vld_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef PARITY_CHK_EN
    logic par_err_q, par_err_d;
    logic par_bad;

    // Even parity: data bits XOR parity bit must be zero.
    assign par_bad = (state_q == PAR) && din_vld && !start && ((^sr_q) ^ din);

    always_comb begin
        par_err_d = err_clr ? 1'b0 : par_err_q;
        if (par_bad) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign Q     = q_q;
    assign q_vld = q_vld_q;
    assign busy  = (state_q != IDLE);
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_shift_deser.sv
// Randomized + directed bench for shift_deser: frame-level reference model feeds a scoreboard
// that a negedge monitor drains on every output handshake.
module tb_shift_deser;

    localparam int W = 4;
`ifdef PARITY_CHK_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         clr, start, msb_first, din, din_vld, q_rdy, err_clr;
    logic [W-1:0] Q;
    logic         q_vld, busy, ovr, par_err;

    shift_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .msb_first (msb_first),
        .din       (din),
        .din_vld   (din_vld),
        .q_rdy     (q_rdy),
        .err_clr   (err_clr),
        .Q         (Q),
        .q_vld     (q_vld),
        .busy      (busy),
        .ovr       (ovr),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] sb[$];

    // Reference model state: frame as a list of received bits, output slot as word+flag.
    bit           in_frame = 1'b0;
    bit           m_msb    = 1'b0;
    bit           bits[$];
    logic [W-1:0] exp_q    = '0;
    bit           exp_vld  = 1'b0;
    bit           exp_busy = 1'b0;
    bit           exp_ovr  = 1'b0;
    bit           exp_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        bits.delete();
        exp_q    = '0;
        exp_vld  = 1'b0;
        exp_busy = 1'b0;
        exp_ovr  = 1'b0;
        exp_perr = 1'b0;
        sb.delete();
    endtask

    // One clock cycle of stimulus; the model predicts the effect of the coming edge.
    task automatic cycle(input bit s, input bit m, input bit d, input bit v, input bit r, input bit ec);
        bit           load;
        bit           perr;
        bit           n_vld, n_ovr, n_perr;
        logic [W-1:0] word;
        logic [W-1:0] n_q;
        start     = s;
        msb_first = m;
        din       = d;
        din_vld   = v;
        q_rdy     = r;
        err_clr   = ec;
        load = 1'b0;
        perr = 1'b0;
        word = '0;
        if (s) begin
            in_frame = 1'b1;
            bits.delete();
            m_msb = m;
        end else if (in_frame && v) begin
            bits.push_back(d);
            if (bits.size() == FLEN) begin
                load = 1'b1;
                for (int i = 0; i < W; i++) begin
                    if (m_msb) word[W-1-i] = bits[i];
                    else       word[i]     = bits[i];
                end
`ifdef PARITY_CHK_EN
                begin
                    bit x;
                    x = 1'b0;
                    for (int i = 0; i < FLEN; i++) x ^= bits[i];
                    perr = x;
                end
`endif
                in_frame = 1'b0;
            end
        end
        n_q    = exp_q;
        n_vld  = exp_vld;
        n_ovr  = ec ? 1'b0 : exp_ovr;
        n_perr = ec ? 1'b0 : exp_perr;
        if (load) begin
            if (!exp_vld || r) begin
                n_q   = word;
                n_vld = 1'b1;
                sb.push_back(word);
            end else begin
                n_ovr = 1'b1;
            end
            if (perr) n_perr = 1'b1;
        end else if (exp_vld && r) begin
            n_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_q    = n_q;
        exp_vld  = n_vld;
        exp_ovr  = n_ovr;
        exp_perr = n_perr;
        exp_busy = in_frame;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, r, 1'b0);
    endtask

    // Start cycle (with a bit that must be ignored) then seq[n-1]..seq[0], gap idles between bits.
    task automatic send(input logic [W:0] seq, input int n, input bit m, input int gap, input bit r);
        cycle(1'b1, m, 1'b1, 1'b1, r, 1'b0);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b0, 1'($urandom), seq[i], 1'b1, r, 1'b0);
            if (i > 0) idle(gap, r);
        end
    endtask

    function automatic logic [W:0] fseq(input logic [W-1:0] tx);
`ifdef PARITY_CHK_EN
        return {tx, ^tx};
`else
        return {1'b0, tx};
`endif
    endfunction

    task automatic do_reset();
        clr     = 1'b0;
        start   = 1'b0;
        din_vld = 1'b0;
        err_clr = 1'b0;
        model_reset();
        #2;
        check("rst_Q", Q, 0);
        check("rst_q_vld", q_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_par_err", par_err, 0);
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    // Monitor: per-cycle output compare plus scoreboard pop on every accepted word.
    initial begin
        logic [W-1:0] w;
        forever begin
            @(negedge clk);
            check("q_vld", q_vld, exp_vld);
            check("Q", Q, exp_q);
            check("busy", busy, exp_busy);
            check("ovr", ovr, exp_ovr);
            check("par_err", par_err, exp_perr);
            if (clr === 1'b1 && q_vld === 1'b1 && q_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_pop: got word %0h, expected no word at %0t", Q, $time);
                end else begin
                    w = sb.pop_front();
                    check("sb_word", Q, w);
                end
            end
        end
    end

    initial begin
        clr = 1'b0; start = 1'b0; msb_first = 1'b0; din = 1'b0;
        din_vld = 1'b0; q_rdy = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Basic msb-first frame, consumer always ready.
        send(fseq(4'b1000), FLEN, 1'b1, 0, 1'b1);
        idle(3, 1'b1);
        // lsb-first with idle gaps between bits.
        send(fseq(4'b1000), FLEN, 1'b0, 2, 1'b1);
        idle(3, 1'b1);
        // Overrun: second word dropped while first is unaccepted, then error clear.
        send(fseq(4'b0110), FLEN, 1'b1, 0, 1'b0);
        send(fseq(4'b1111), FLEN, 1'b1, 0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(3, 1'b1);
        // Reset mid-frame, stray bit before restart, then clean frame.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send(fseq(4'b1101), FLEN, 1'b1, 0, 1'b1);
        idle(3, 1'b1);
        // Restart after three bits: only the second frame produces a word.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(fseq(4'b0101), FLEN, 1'b1, 0, 1'b1);
        idle(3, 1'b1);
`ifdef PARITY_CHK_EN
        send({4'b0110, 1'b0}, FLEN, 1'b1, 0, 1'b1);
        idle(2, 1'b1);
        send({4'b0111, 1'b0}, FLEN, 1'b1, 0, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
`endif
        // Random traffic with ready bursts high and low.
        for (int i = 0; i < 600; i++) begin
            bit r;
            r = ((i / 16) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 24) == 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0, r, $urandom_range(0, 19) == 0);
        end
        idle(10, 1'b1);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, word length in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  synchronous frame start; restarts any frame in progress.
REQ-005 SHALL have port msb_first  input  1  bit order, sampled only in the start cycle: 1 = first bit lands in Q[WIDTH-1] (left shift); 0 = first bit lands in Q[0] (right shift).
REQ-006 SHALL have port din  input  1  serial data bit.
REQ-007 SHALL have port din_vld  input  1  din is valid this cycle.
REQ-008 SHALL have port q_rdy  input  1  consumer accepts Q when q_vld && q_rdy.
REQ-009 SHALL have port err_clr  input  1  synchronous clear of ovr and par_err.
REQ-010 SHALL have port Q  output  WIDTH  assembled parallel word.
REQ-011 SHALL have port q_vld  output  1  Q holds an unaccepted word.
REQ-012 SHALL have port busy  output  1  frame in progress (state != IDLE).
REQ-013 SHALL have port ovr  output  1  sticky overrun flag.
REQ-014 SHALL have port par_err  output  1  sticky parity error flag; tied 0 when PARITY_CHK_EN is undefined.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, PAR (PAR exists only with PARITY_CHK_EN).
REQ-016 IDLE + start -> SHIFT next edge; bit counter = 0; msb_first latched; din_vld in that cycle is ignored.
REQ-017 In SHIFT, each din_vld cycle shifts din into the internal shift register per latched order and increments the counter; cycles without din_vld hold state.
REQ-018 On the din_vld that makes the count WIDTH: without the macro -> IDLE and output load on that same edge (q_vld high in the following cycle); with the macro -> PAR.
REQ-019 start while in SHIFT or PAR discards the partial word, re-latches msb_first, resets the counter, and stays or returns to SHIFT; it is not an error.
REQ-020 Output load: Q <= shift register, q_vld <= 1 if q_vld was 0 or q_rdy is 1 in the load cycle.
REQ-021 If q_vld = 1 and q_rdy = 0 in the load cycle, the new word SHALL be dropped, Q and q_vld SHALL be unchanged, and ovr SHALL be set to 1.
REQ-022 q_vld && q_rdy with no load in that cycle SHALL clear q_vld next edge; Q SHALL hold its value.
REQ-023 Q, q_vld, and the q_rdy handshake SHALL be independent of FSM state; a new frame may collect while q_vld is high.
REQ-024 err_clr SHALL clear ovr and par_err next edge; a set event in the same cycle SHALL win.

Reset
REQ-025 clr low SHALL force asynchronously: state IDLE, counter 0, shift register 0, Q 0, q_vld 0, busy 0, ovr 0, par_err 0.
REQ-026 Reset mid-frame SHALL discard the partial word without setting ovr; operation resumes only on the next start after clr rises.

Configuration
REQ-027 Macro PARITY_CHK_EN defined: after WIDTH data bits, the next din_vld bit SHALL be taken as even parity (XOR of data and parity bits = 0) in state PAR, followed by IDLE and output load per REQ-020/021.
REQ-028 On a parity mismatch, the word SHALL still be loaded and par_err SHALL be set to 1.
REQ-029 Macro undefined: the PAR state and parity logic SHALL be absent, and par_err SHALL be constant 0.

Verification
REQ-030 WIDTH=4, msb_first=1, q_rdy=1, bits 1,0,0,0 on consecutive din_vld -> Q=4'b1000 and q_vld high for 1 cycle, starting the cycle after the last bit.
REQ-031 Same bits with msb_first=0 and din_vld gaps of 2 idle cycles between bits -> Q=4'b0001; busy high from the cycle after start until the last bit.
REQ-032 q_rdy=0; frame 0110 then frame 1111 -> Q stays 4'b0110, q_vld=1, ovr=1; err_clr pulse -> ovr=0.
REQ-033 clr pulsed low after 2 bits, then start and bits 1,1,0,1 (msb_first=1) -> Q=4'b1101, ovr=0, no stale bits in Q.
REQ-034 start re-asserted after 3 bits, then 4 bits 0,1,0,1 (msb_first=1) -> single word Q=4'b0101.
REQ-035 PARITY_CHK_EN defined: data 0110 with parity 0 -> par_err=0; data 0111 with parity 0 -> Q=4'b0111 and par_err=1.
